// File: rtl/gpio_bank_if.sv
// gpio_bank_if: single-cycle register bus between the execute stage and the
// GPIO bank. The master drives the access, the slave returns registered read data.
interface gpio_bank_if #(
  parameter int WIDTH = 32
) ();
  logic [2:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;

  modport master (
    output addr, wdata, we, re,
    input  rdata, rvalid
  );

  modport slave (
    input  addr, wdata, we, re,
    output rdata, rvalid
  );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO controller.
// Features: input synchroniser, atomic set/clear of output bits, one-cycle
// registered reads, and read-before-write when a read and a write hit together.
// Optional macro GPIO_EDGE_EN adds sticky edge flags (STATUS, write-1-to-clear),
// the RISE_EN/FALL_EN/IRQ_EN registers, a priming counter and the level irq.
// Without it, addresses 4-7 read 0 and ignore writes, and irq_o is tied low.
module gpio_bank #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] gpio_in_i,
  output logic [WIDTH-1:0] gpio_out_o,
  output logic             irq_o,
  gpio_bank_if.slave       bus
);

  localparam logic [2:0] ADDR_OUT     = 3'd0;
  localparam logic [2:0] ADDR_SET     = 3'd1;
  localparam logic [2:0] ADDR_CLR     = 3'd2;
  localparam logic [2:0] ADDR_IN      = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;
  localparam logic [2:0] ADDR_RISE_EN = 3'd5;
  localparam logic [2:0] ADDR_FALL_EN = 3'd6;
  localparam logic [2:0] ADDR_IRQ_EN  = 3'd7;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] syncOut;
  logic [WIDTH-1:0] gpioOut_q;
  logic [WIDTH-1:0] gpioOut_d;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;
  logic [WIDTH-1:0] readMux;
  logic [WIDTH-1:0] edgeRdata;

  assign syncOut    = sync_q[SYNC_STAGES-1];
  assign gpio_out_o = gpioOut_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

  // Multi-flop synchroniser that brings the asynchronous pins into clk_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Next output-pin value: plain load, atomic set or atomic clear
  always_comb begin
    gpioOut_d = gpioOut_q;
    if (bus.we) begin
      case (bus.addr)
        ADDR_OUT: gpioOut_d = bus.wdata;
        ADDR_SET: gpioOut_d = gpioOut_q | bus.wdata;
        ADDR_CLR: gpioOut_d = gpioOut_q & ~bus.wdata;
        default:  gpioOut_d = gpioOut_q;
      endcase
    end
  end

  // Output pin register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) gpioOut_q <= '0;
    else         gpioOut_q <= gpioOut_d;
  end

`ifdef GPIO_EDGE_EN
  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;
  logic [WIDTH-1:0] riseEn_q;
  logic [WIDTH-1:0] fallEn_q;
  logic [WIDTH-1:0] irqEn_q;
  logic [2:0]       primeCnt_q;
  logic             irq_q;
  logic             primed;
  logic [WIDTH-1:0] edgeHit;

  assign primed = (primeCnt_q == PRIME_MAX);
  assign irq_o  = irq_q;

  // Edge flags: W1C clears first, then new edges are OR-ed in so a coincident edge wins
  always_comb begin
    edgeHit  = '0;
    if (primed) begin
      edgeHit = (syncOut & ~prev_q & riseEn_q) | (~syncOut & prev_q & fallEn_q);
    end
    status_d = status_q;
    if (bus.we && (bus.addr == ADDR_STATUS)) status_d = status_q & ~bus.wdata;
    status_d = status_d | edgeHit;
  end

  // Edge-detect state, enable registers, saturating priming counter and irq
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q     <= '0;
      status_q   <= '0;
      riseEn_q   <= '0;
      fallEn_q   <= '0;
      irqEn_q    <= '0;
      primeCnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q   <= syncOut;
      status_q <= status_d;
      if (!primed) primeCnt_q <= primeCnt_q + 3'd1;
      if (bus.we) begin
        case (bus.addr)
          ADDR_RISE_EN: riseEn_q <= bus.wdata;
          ADDR_FALL_EN: fallEn_q <= bus.wdata;
          ADDR_IRQ_EN:  irqEn_q  <= bus.wdata;
          default: ;
        endcase
      end
      irq_q <= |(status_q & irqEn_q);
    end
  end

  // Readback of the edge-detection registers
  always_comb begin
    edgeRdata = '0;
    case (bus.addr)
      ADDR_STATUS:  edgeRdata = status_q;
      ADDR_RISE_EN: edgeRdata = riseEn_q;
      ADDR_FALL_EN: edgeRdata = fallEn_q;
      ADDR_IRQ_EN:  edgeRdata = irqEn_q;
      default:      edgeRdata = '0;
    endcase
  end
`else
  assign edgeRdata = '0;
  assign irq_o     = 1'b0;
`endif

  // Read multiplexer built from pre-write register values
  always_comb begin
    readMux = '0;
    case (bus.addr)
      ADDR_OUT: readMux = gpioOut_q;
      ADDR_SET: readMux = '0;
      ADDR_CLR: readMux = '0;
      ADDR_IN:  readMux = syncOut;
      default:  readMux = edgeRdata;
    endcase
  end

  // Registered read port: data valid for exactly one cycle, zero when idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= bus.re ? readMux : '0;
      rvalid_q <= bus.re;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: scoreboard bench for gpio_bank (WIDTH=32, SYNC_STAGES=2).
// Reads push their expected data into a queue; a monitor pops on every rvalid.
// Edge/irq checks are compiled in when GPIO_EDGE_EN is defined.
module tb_gpio_bank;
  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  gpioIn;
  logic [W-1:0]  gpioOut;
  logic          irq;

  logic [W-1:0]  expQ [$];
  int            total = 0;
  int            bad   = 0;

  gpio_bank_if #(.WIDTH(W)) busIf ();

  gpio_bank #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .gpio_in_i  (gpioIn),
    .gpio_out_o (gpioOut),
    .irq_o      (irq),
    .bus        (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and log a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one bus cycle at the falling edge; reads queue their expected data
  task automatic applyStimulus(input logic w, input logic r, input logic [2:0] a,
                               input logic [W-1:0] d, input logic [W-1:0] expRead);
    @(negedge clk);
    busIf.we    = w;
    busIf.re    = r;
    busIf.addr  = a;
    busIf.wdata = d;
    if (r) expQ.push_back(expRead);
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    applyStimulus(1'b1, 1'b0, a, d, '0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [W-1:0] e);
    applyStimulus(1'b0, 1'b1, a, '0, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, '0, '0);
  endtask

  // Monitor: every valid read is matched against the oldest queued expectation
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (busIf.rvalid) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_rvalid: got rdata %h expected no read", busIf.rdata);
        end else begin
          e = expQ.pop_front();
          if (busIf.rdata !== e) begin
            bad++;
            $display("[TB] FAIL read_data: got %h expected %h", busIf.rdata, e);
          end
        end
      end else begin
        total++;
        if (busIf.rdata !== '0) begin
          bad++;
          $display("[TB] FAIL idle_rdata: got %h expected 0", busIf.rdata);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    gpioIn      = '1;
    busIf.we    = 1'b0;
    busIf.re    = 1'b0;
    busIf.addr  = 3'd0;
    busIf.wdata = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_gpio_out", gpioOut, '0);
    checkOutput("reset_irq", {31'b0, irq}, '0);
    checkOutput("reset_rvalid", {31'b0, busIf.rvalid}, '0);
    rst_n = 1'b1;

    // Priming: pins high at release with every rise enabled must not set STATUS
    wr(3'd5, 32'hFFFF_FFFF);
    idle(6);
    rd(3'd4, 32'h0);
    rd(3'd3, 32'hFFFF_FFFF);
`ifdef GPIO_EDGE_EN
    rd(3'd5, 32'hFFFF_FFFF);
`else
    rd(3'd5, 32'h0);
`endif
    idle(1);
    checkOutput("prime_gpio_out", gpioOut, '0);
    checkOutput("prime_irq", {31'b0, irq}, '0);

    wr(3'd5, 32'h0);
    gpioIn = '0;
    idle(4);

    // OUT / OUT_SET / OUT_CLR sequence
    wr(3'd0, 32'h0000_00F0);
    wr(3'd1, 32'h0000_000F);
    checkOutput("out_load", gpioOut, 32'h0000_00F0);
    wr(3'd2, 32'h0000_0030);
    checkOutput("out_set", gpioOut, 32'h0000_00FF);
    idle(1);
    checkOutput("out_clr", gpioOut, 32'h0000_00CF);
    rd(3'd1, 32'h0);
    rd(3'd2, 32'h0);
    rd(3'd0, 32'h0000_00CF);

    // Same-cycle write and read of OUT returns the old value
    wr(3'd0, 32'h0000_0012);
    applyStimulus(1'b1, 1'b1, 3'd0, 32'h0000_0034, 32'h0000_0012);
    rd(3'd0, 32'h0000_0034);

    // Input path pattern
    idle(1);
    gpioIn = 32'h0000_A5C3;
    idle(3);
    rd(3'd3, 32'h0000_A5C3);
    idle(1);
    gpioIn = '0;
    idle(3);

`ifdef GPIO_EDGE_EN
    // Rising edge on bit 0 with irq enabled: irq at the fourth edge after the pin change
    wr(3'd5, 32'h1);
    wr(3'd7, 32'h1);
    wr(3'd4, 32'hFFFF_FFFF);
    idle(3);
    gpioIn = 32'h1;
    idle(1);
    checkOutput("rise_irq_n1", {31'b0, irq}, '0);
    rd(3'd3, 32'h1);
    checkOutput("rise_irq_n2", {31'b0, irq}, '0);
    rd(3'd4, 32'h1);
    checkOutput("rise_irq_n3", {31'b0, irq}, '0);
    idle(1);
    checkOutput("rise_irq_n4", {31'b0, irq}, 32'h1);

    // W1C coinciding with a new rising edge: set wins
    gpioIn = '0;
    idle(4);
    checkOutput("hold_irq", {31'b0, irq}, 32'h1);
    gpioIn = 32'h1;
    idle(1);
    wr(3'd4, 32'h1);
    idle(1);
    checkOutput("coincide_irq_a", {31'b0, irq}, 32'h1);
    rd(3'd4, 32'h1);
    checkOutput("coincide_irq_b", {31'b0, irq}, 32'h1);

    // W1C with no edge: irq drops one cycle after the clearing edge
    wr(3'd4, 32'h1);
    idle(1);
    checkOutput("w1c_irq_c1", {31'b0, irq}, 32'h1);
    idle(1);
    checkOutput("w1c_irq_c2", {31'b0, irq}, '0);
    rd(3'd4, 32'h0);

    // Falling edge detection
    wr(3'd5, 32'h0);
    wr(3'd6, 32'h1);
    gpioIn = '0;
    idle(4);
    rd(3'd4, 32'h1);
    checkOutput("fall_irq", {31'b0, irq}, 32'h1);
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd6, 32'h0);

    // Build up STATUS=0x5 before the mid-stream reset
    wr(3'd5, 32'h5);
    gpioIn = 32'h5;
    idle(4);
    rd(3'd4, 32'h5);
`else
    // Edge registers absent: reads of 4-7 are zero, writes vanish, irq stays low
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd5, 32'hFFFF_FFFF);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    gpioIn = 32'h5;
    idle(4);
    rd(3'd4, 32'h0);
    rd(3'd5, 32'h0);
    rd(3'd6, 32'h0);
    rd(3'd7, 32'h0);
    gpioIn = 32'h0;
    idle(4);
    checkOutput("noedge_irq", {31'b0, irq}, '0);
    gpioIn = 32'h5;
`endif
    wr(3'd0, 32'h0000_00AA);
    idle(2);
    checkOutput("pre_reset_gpio_out", gpioOut, 32'h0000_00AA);

    // Asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_gpio_out", gpioOut, '0);
    checkOutput("async_irq", {31'b0, irq}, '0);
    checkOutput("async_rvalid", {31'b0, busIf.rvalid}, '0);
    gpioIn = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(3'd0, 32'h0);
    rd(3'd4, 32'h0);
    rd(3'd5, 32'h0);
    rd(3'd7, 32'h0);
    idle(2);
    checkOutput("post_reset_irq", {31'b0, irq}, '0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1);
    idle(2);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL missing_reads: got %0d pending expected 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
